// File: rtl/decode_stage.sv
// decode_stage: single-entry decode pipeline register between fetch and execute.
// Decodes the opcode class into one-hot control bits, extracts register fields
// and the immediate/target, and inserts a bubble on a load-use dependency.
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int CNT_W     = 16,
    parameter int HAZARD_EN = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_insn,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [PC_W-1:0]   out_pc,
    output logic [15:0]       out_ctrl,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [31:0]       out_imm,
    output logic [26:0]       out_target,
    output logic [CNT_W-1:0]  cnt_insn,
    output logic [CNT_W-1:0]  cnt_bubble,
    output logic              err_illegal
);

    // Control bit positions
    localparam int C_ALU  = 0;
    localparam int C_ADDI = 1;
    localparam int C_SW   = 2;
    localparam int C_LW   = 3;
    localparam int C_J    = 4;
    localparam int C_JR   = 5;
    localparam int C_JAL  = 6;
    localparam int C_BLT  = 7;
    localparam int C_BNE  = 8;
    localparam int C_BEX  = 9;
    localparam int C_SETX = 10;
    localparam int C_ADD  = 11;
    localparam int C_SUB  = 12;
    localparam int C_MUL  = 13;
    localparam int C_DIV  = 14;
    localparam int C_ILL  = 15;

    // Opcode class decode; an illegal opcode or aluop yields only the ILLEGAL bit.
    function automatic logic [15:0] decode_ctrl(input logic [31:0] insn);
        logic [15:0] c;
        c = '0;
        case (insn[31:27])
            5'b00000: begin
                case (insn[6:2])
                    5'b00000: begin c[C_ALU] = 1'b1; c[C_ADD] = 1'b1; end
                    5'b00001: begin c[C_ALU] = 1'b1; c[C_SUB] = 1'b1; end
                    5'b00110: begin c[C_ALU] = 1'b1; c[C_MUL] = 1'b1; end
                    5'b00111: begin c[C_ALU] = 1'b1; c[C_DIV] = 1'b1; end
                    5'b00010, 5'b00011,
                    5'b00100, 5'b00101: c[C_ALU] = 1'b1;
                    default:            c[C_ILL] = 1'b1;
                endcase
            end
            5'b00001: c[C_J]    = 1'b1;
            5'b00010: c[C_BNE]  = 1'b1;
            5'b00011: c[C_JAL]  = 1'b1;
            5'b00100: c[C_JR]   = 1'b1;
            5'b00101: c[C_ADDI] = 1'b1;
            5'b00110: c[C_BLT]  = 1'b1;
            5'b00111: c[C_SW]   = 1'b1;
            5'b01000: c[C_LW]   = 1'b1;
            5'b10101: c[C_SETX] = 1'b1;
            5'b10110: c[C_BEX]  = 1'b1;
            default:  c[C_ILL]  = 1'b1;
        endcase
        return c;
    endfunction

    // True when register r is one of the sources read by insn (class c).
    function automatic logic src_hit(input logic [15:0] c, input logic [31:0] insn,
                                     input logic [4:0] r);
        logic hit;
        hit = 1'b0;
        if (c[C_ALU])
            hit = (insn[21:17] == r) || (insn[16:12] == r);
        if (c[C_ADDI] || c[C_LW])
            hit = (insn[21:17] == r);
        if (c[C_SW] || c[C_BNE] || c[C_BLT])
            hit = (insn[26:22] == r) || (insn[21:17] == r);
        if (c[C_JR])
            hit = (insn[26:22] == r);
        if (c[C_BEX])
            hit = (r == 5'd30);
        return hit;
    endfunction

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == {CNT_W{1'b1}})
            return c;
        else
            return c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic                vld_p1;
    logic [31:0]         insn_p1;
    logic [PC_W-1:0]     pc_p1;
    logic [15:0]         ctrl_p1;
    logic [4:0]          rd_p1;
    logic [4:0]          rs_p1;
    logic [4:0]          rt_p1;
    logic signed [31:0]  imm_p1;
    logic [26:0]         target_p1;
    logic [CNT_W-1:0]    cnt_insn_q;
    logic [CNT_W-1:0]    cnt_bubble_q;
    logic                err_q;

    logic [15:0]         dec_ctrl;
    logic signed [31:0]  dec_imm;
    logic                hz;
    logic                xfer_in;
    logic                xfer_out;

    assign dec_ctrl = decode_ctrl(in_insn);
    assign dec_imm  = {{15{in_insn[16]}}, in_insn[16:0]};

    // Load-use interlock: a held LW whose destination feeds the incoming instruction.
    assign hz = (HAZARD_EN != 0) && vld_p1 && ctrl_p1[C_LW] && in_valid &&
                (rd_p1 != 5'd0) && src_hit(dec_ctrl, in_insn, rd_p1);

    assign in_ready = (!vld_p1 || out_ready) && !hz && !flush;
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = vld_p1 && out_ready;

    // Stage p0 -> p1: flush drains, accept loads, drain without accept makes a bubble.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            insn_p1   <= '0;
            pc_p1     <= '0;
            ctrl_p1   <= '0;
            rd_p1     <= '0;
            rs_p1     <= '0;
            rt_p1     <= '0;
            imm_p1    <= '0;
            target_p1 <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
        end else if (xfer_in) begin
            vld_p1    <= 1'b1;
            insn_p1   <= in_insn;
            pc_p1     <= in_pc;
            ctrl_p1   <= dec_ctrl;
            rd_p1     <= in_insn[26:22];
            rs_p1     <= in_insn[21:17];
            rt_p1     <= in_insn[16:12];
            imm_p1    <= dec_imm;
            target_p1 <= in_insn[26:0];
        end else if (xfer_out) begin
            vld_p1    <= 1'b0;
        end
    end

    // Statistics: accepted instructions, hazard bubbles, sticky illegal flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_insn_q   <= '0;
            cnt_bubble_q <= '0;
            err_q        <= 1'b0;
        end else if (!flush) begin
            if (xfer_in)
                cnt_insn_q <= sat_inc(cnt_insn_q);
            if (hz && out_ready)
                cnt_bubble_q <= sat_inc(cnt_bubble_q);
            if (xfer_in && dec_ctrl[C_ILL])
                err_q <= 1'b1;
        end
    end

    assign out_valid   = vld_p1;
    assign out_insn    = insn_p1;
    assign out_pc      = pc_p1;
    assign out_ctrl    = ctrl_p1;
    assign out_rd      = rd_p1;
    assign out_rs      = rs_p1;
    assign out_rt      = rt_p1;
    assign out_imm     = imm_p1;
    assign out_target  = target_p1;
    assign cnt_insn    = cnt_insn_q;
    assign cnt_bubble  = cnt_bubble_q;
    assign err_illegal = err_q;

endmodule
